// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory arbiter, its
// request checker and data_memory itself.
//   OPC_*          : opcodes understood by data_memory (NOP = idle bus)
//   F3_*           : RV32I load/store fun3 encodings
//   memory_op_type : memory operation kind, shared with data_memory
//   arb_state_t    : arbiter sequencer states
package dmem_pkg;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_NOP   = 7'b0000000;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {MEM_NOP, MEM_LOAD, MEM_STORE} memory_op_type;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
endpackage

// File: rtl/dmem_req_check.sv
// dmem_req_check: combinational legality check of one load/store request.
//   we    in  : 1 = store, 0 = load
//   addr  in  : byte address
//   fun3  in  : RV32I load/store fun3
//   legal out : request is a supported fun3, naturally aligned and in range
module dmem_req_check
    import dmem_pkg::*;
#(
    parameter int SIZE = 1024
) (
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  fun3,
    output logic        legal
);
    logic fun3_ok;
    logic align_ok;
    logic range_ok;

    // Stores have no unsigned variants; loads accept BU/HU as well.
    assign fun3_ok  = (fun3 == F3_B) || (fun3 == F3_H) || (fun3 == F3_W) ||
                      (!we && (fun3 == F3_BU || fun3 == F3_HU));
    assign align_ok = (fun3 == F3_W) ? (addr[1:0] == 2'b00) :
                      (fun3 == F3_H || fun3 == F3_HU) ? !addr[0] : 1'b1;
    assign range_ok = addr < 32'(4 * SIZE);
    assign legal    = fun3_ok && align_ok && range_ok;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for data_memory.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/ready/we    : per-port request handshake and direction
//   req_addr*/fun3_*/wdata*: per-port request payload
//   resp_valid/err/rdata  : registered one-cycle response to the granted port
//   mem_*                 : command bus to data_memory, mem_rdata its data_out
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [2:0]  req_fun3_0,
    input  logic [2:0]  req_fun3_1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_fun3,
    output logic [6:0]  mem_opcode,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    arb_state_t  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  fun3_q, fun3_d;

    logic        sel;
    logic        hs;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_fun3;
    logic        legal;

    // On a tie the port not granted last wins; otherwise the lone valid port.
    always_comb begin
        sel       = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        hs        = (state_q == IDLE) && (|req_valid);
        sel_we    = req_we[sel];
        sel_addr  = sel ? req_addr1 : req_addr0;
        sel_fun3  = sel ? req_fun3_1 : req_fun3_0;
        sel_wdata = sel ? req_wdata1 : req_wdata0;
    end

    dmem_req_check #(.SIZE(SIZE)) u_check (
        .we    (sel_we),
        .addr  (sel_addr),
        .fun3  (sel_fun3),
        .legal (legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            fun3_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            fun3_q       <= fun3_d;
        end
    end

    // Illegal requests skip ACCESS so data_memory never sees them.
    always_comb begin
        state_d = (state_q == IDLE)   ? (hs ? (legal ? ACCESS : RESP) : IDLE) :
                  (state_q == ACCESS) ? RESP : IDLE;
    end

    always_comb begin
        grant_d      = hs ? sel : grant_q;
        we_d         = hs ? sel_we : we_q;
        addr_d       = hs ? sel_addr : addr_q;
        fun3_d       = hs ? sel_fun3 : fun3_q;
        wdata_d      = hs ? sel_wdata : wdata_q;
        err_d        = hs ? !legal : err_q;
        rdata_d      = hs ? 32'd0 : (state_q == ACCESS) ? (we_q ? 32'd0 : mem_rdata) : rdata_q;
        last_grant_d = (state_q == RESP) ? grant_q : last_grant_q;
    end

    always_comb begin
        req_ready  = hs ? (sel ? 2'b10 : 2'b01) : 2'b00;
        mem_write  = (state_q == ACCESS) && we_q;
        mem_read   = (state_q == ACCESS) && !we_q;
        mem_addr   = (state_q == ACCESS) ? addr_q : 32'd0;
        mem_fun3   = (state_q == ACCESS) ? fun3_q : 3'd0;
        mem_wdata  = (state_q == ACCESS) ? wdata_q : 32'd0;
        mem_opcode = (state_q == ACCESS) ? (we_q ? OPC_STORE : OPC_LOAD) : OPC_NOP;
        resp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
    end
endmodule
